// File: rtl/load_use_scoreboard_pkg.sv
// load_use_scoreboard_pkg
// Shared opcode constants for the load-use hazard unit, plus a helper that
// classifies an instruction as a register-writing load.
// No ports (package).
package load_use_scoreboard_pkg;

  localparam logic [6:0] LOAD_OP  = 7'b0000011;
  localparam logic [6:0] STORE_OP = 7'b0100011;

  // True when the instruction is a load that actually writes a register.
  function automatic logic is_reg_load(input logic [6:0] opcode, input logic wr_reg_n);
    return (opcode == LOAD_OP) && !wr_reg_n;
  endfunction

endpackage

// File: rtl/load_use_scoreboard_slot_pipe.sv
// load_slot_pipe
// DEPTH-deep {valid, rd} shift register tracking loads in flight after EX.
// Slot 0 takes the pushed entry (or a bubble when push_valid_i is low);
// slot k+1 takes slot k; the last slot drops off. hold_i freezes every slot.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   hold_i          freeze all slots
//   push_valid_i    slot 0 becomes valid with push_rd_i (else bubble)
//   push_rd_i       destination register of the pushed load
//   valid_o         valid bit per slot
//   rd_o            rd per slot, slot k at [k*REG_W +: REG_W]
module load_slot_pipe #(
  parameter int DEPTH = 1,
  parameter int REG_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold_i,
  input  logic                   push_valid_i,
  input  logic [REG_W-1:0]       push_rd_i,
  output logic [DEPTH-1:0]       valid_o,
  output logic [DEPTH*REG_W-1:0] rd_o
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [REG_W-1:0] rd_q [DEPTH];
  logic [REG_W-1:0] rd_d [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      if (gi == 0) begin : g_head
        assign valid_d[gi] = push_valid_i;
        assign rd_d[gi]    = push_rd_i;
      end else begin : g_tail
        assign valid_d[gi] = valid_q[gi-1];
        assign rd_d[gi]    = rd_q[gi-1];
      end
      assign valid_o[gi]               = valid_q[gi];
      assign rd_o[gi*REG_W +: REG_W]   = rd_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) rd_q[k] <= '0;
    end else if (!hold_i) begin
      valid_q <= valid_d;
      for (int k = 0; k < DEPTH; k++) rd_q[k] <= rd_d[k];
    end
  end

endmodule

// File: rtl/load_use_scoreboard.sv
// load_use_scoreboard
// Load-use hazard unit beside ID. Tracks issued loads for LOAD_LAT cycles
// after they leave EX and stalls ID while a source operand depends on a load
// whose data cannot yet be forwarded. Store rs2 is exempt when the load sits
// in the last slot, since store data is forwarded at MEM.
// Optional feature: define LOAD_USE_PERF_EN to build a saturating stall-cycle
// counter; otherwise stall_count is tied to 0.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_valid                 ID holds a real instruction
//   opcode_in_id             ID opcode
//   rs1, rs2                 ID source indices
//   rs1_used, rs2_used       ID instruction reads that source
//   rd_in_id                 ID destination index
//   wr_reg_n_in_id           active-low register write enable
//   hold                     whole-pipeline freeze
//   flush                    squash the ID instruction
//   stall                    hold PC/IF/ID, inject EX bubble (combinational)
//   pending                  valid bit of each aging slot
//   stall_count              stall-cycle counter
module load_use_scoreboard
  import load_use_scoreboard_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int REG_W    = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [6:0]          opcode_in_id,
  input  logic [REG_W-1:0]    rs1,
  input  logic [REG_W-1:0]    rs2,
  input  logic                rs1_used,
  input  logic                rs2_used,
  input  logic [REG_W-1:0]    rd_in_id,
  input  logic                wr_reg_n_in_id,
  input  logic                hold,
  input  logic                flush,
  output logic                stall,
  output logic [LOAD_LAT-1:0] pending,
  output logic [31:0]         stall_count
);

  logic [LOAD_LAT-1:0]       slot_valid;
  logic [LOAD_LAT*REG_W-1:0] slot_rd;
  logic [LOAD_LAT-1:0]       rs1_hit, rs2_hit, rs2_stall_mask;
  logic                      is_store, issue, push_valid;

  assign is_store = (opcode_in_id == STORE_OP);

  genvar gi;
  generate
    for (gi = 0; gi < LOAD_LAT; gi++) begin : g_match
      assign rs1_hit[gi] = slot_valid[gi] & rs1_used & (rs1 != '0) &
                           (rs1 == slot_rd[gi*REG_W +: REG_W]);
      assign rs2_hit[gi] = slot_valid[gi] & rs2_used & (rs2 != '0) &
                           (rs2 == slot_rd[gi*REG_W +: REG_W]);
      // A store picks up its rs2 data at MEM, so a producer in the oldest
      // slot is already forwardable in time.
      if (gi == LOAD_LAT - 1) begin : g_last
        assign rs2_stall_mask[gi] = !is_store;
      end else begin : g_early
        assign rs2_stall_mask[gi] = 1'b1;
      end
    end
  endgenerate

  assign stall = id_valid & !flush & ((|rs1_hit) | (|(rs2_hit & rs2_stall_mask)));

  // A stalled or flushed instruction never issues; slot 0 then takes a bubble
  // while older loads keep aging.
  assign issue      = id_valid & !stall & !flush;
  assign push_valid = issue & is_reg_load(opcode_in_id, wr_reg_n_in_id) & (rd_in_id != '0);

  load_slot_pipe #(
    .DEPTH (LOAD_LAT),
    .REG_W (REG_W)
  ) u_slot_pipe (
    .clk          (clk),
    .rst          (rst),
    .hold_i       (hold),
    .push_valid_i (push_valid),
    .push_rd_i    (rd_in_id),
    .valid_o      (slot_valid),
    .rd_o         (slot_rd)
  );

  assign pending = slot_valid;

`ifdef LOAD_USE_PERF_EN
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && !hold && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= 32'd0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: doc/load_use_scoreboard.md
# load_use_scoreboard

Parametrised load-use hazard unit for the rv32i pipeline, generalising the single-cycle load-use stall to memories whose load data becomes forwardable `LOAD_LAT` cycles after the load leaves EX. It sits beside the ID stage:
- It records every issuing load's destination register in a small aging pipeline.
- It stalls ID while any source operand depends on a load whose data cannot yet be forwarded.
- It exempts store `rs2` when MEM-stage forwarding arrives in time.
- It honours pipeline hold and flush.

## Interface
Parameters:
- `LOAD_LAT`, 1: load latency, in cycles, from EX entry until the result is forwardable to EX. Range 1..4. A value of 1 reproduces classic 5-stage behaviour.
- `REG_W`, 5: register index width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `id_valid`  in  1  ID holds a real instruction.
- `opcode_in_id`  in  7  ID opcode.
- `rs1`, `rs2`  in  `REG_W` each  ID source indices.
- `rs1_used`, `rs2_used`  in  1 each  the ID instruction reads that source.
- `rd_in_id`  in  `REG_W`  ID destination index.
- `wr_reg_n_in_id`  in  1  active-low register-write enable of the ID instruction.
- `hold`  in  1  whole-pipeline freeze (memory busy).
- `flush`  in  1  squash the ID instruction (taken branch/jump resolved in EX).
- `stall`  out  1  hold PC/IF/ID and inject an EX bubble.
- `pending`  out  `LOAD_LAT`  valid bit of each aging slot (debug).
- `stall_count`  out  32  stall-cycle counter (see Configuration).

## Operation
- State: `LOAD_LAT` slots `{valid, rd}`. Slot 0 holds the load currently in EX. Slot k holds the load that entered EX k cycles ago.
- Push condition: `issue = id_valid & !stall & !flush`. On issue, if the opcode is LOAD_OP, `!wr_reg_n_in_id` and `rd_in_id != 0`, then slot 0 is loaded with `{1, rd_in_id}`. Otherwise slot 0 takes a bubble (`valid = 0`).
- Advance: each non-hold cycle, slot k+1 takes slot k. The last slot drops off, because its data is now forwardable.
- Match: source s matches slot k when all of the following hold:
  - `slot[k].valid`
  - `s_used`
  - `s != 0`
  - `s == slot[k].rd`
- Stall rules:
  - `rs1` matching any slot causes a stall.
  - `rs2` matching any slot causes a stall, with one exception. If the ID opcode is STORE_OP, a match only in slot `LOAD_LAT-1` does not stall, because store data is forwarded at MEM.
  - `stall = id_valid & !flush & (any stalling match)`.
- Priority: `rst` > `hold` > `flush` > normal.
  - `hold`: all slots and the counter are frozen. `stall` is still driven combinationally.
  - `flush`: the ID instruction is never pushed. Slot 0 takes a bubble and the other slots advance, because older loads remain live.
- Multiple matches, or both sources matching, still produce a single `stall`.

## Timing
- `stall` is purely combinational from the inputs and slot state, with no added latency.
- Slots and the counter update on the rising `clk` edge.
- Reset values: all slot valids 0, `pending = 0`, `stall_count = 0`. Consequently `stall = 0` in the first cycle after reset for any input.
- A dependent instruction stalls for exactly `LOAD_LAT - k` cycles when the producer sits in slot k. A directly following consumer therefore stalls `LOAD_LAT` cycles, or `LOAD_LAT - 1` cycles for a store consuming the load through `rs2`.
- Hold cycles extend the stall without aging, so no wrap-around or data loss occurs.
- If `rst` is asserted mid-stall, the next cycle has all slots cleared and no stall.

## Configuration
- With `LOAD_USE_PERF_EN` defined: `stall_count` increments on every cycle with `stall & !hold & !rst`. The counter saturates at 0xFFFF_FFFF and holds that value.
- Without `LOAD_USE_PERF_EN`: no counter register is built and `stall_count` is tied to 0.

## Structure
- `LOAD_OP` and `STORE_OP` come from the shared opcode constants header, which is the only shared dependency. Nothing new is added to it.
- One sub-module: `load_slot_pipe`. It is the parametrised `LOAD_LAT`-deep `{valid, rd}` shift register with push, bubble and hold inputs. The match/stall logic and the counter remain in the top module.

## Test plan
- `LOAD_LAT=1`: `lw x5` issues, then `add x6,x5,x7` in ID → `stall=1` for 1 cycle, then 0. `pending` goes 1 then 0.
- `LOAD_LAT=1`: `lw x5` then `sw x5,0(x8)` (x5 as `rs2`) → no stall. `lw x5` then `sw x9,0(x5)` (x5 as `rs1`) → 1 stall cycle.
- `LOAD_LAT=3`: `lw x5` then `add x6,x5,x5` → 3 stall cycles. `lw x5` then `nop` then `add` → 2 stall cycles. `lw x5` then `sw x5` → 2 stall cycles.
- `lw x0` or `lui x5` (`rs1_used=0`, `rd` matches) → never stalls. `lw x5` with `wr_reg_n_in_id=1` → no push.
- `LOAD_LAT=2`: `hold=1` for 4 cycles during a stall → `stall` stays 1 and `pending` stays unchanged. After hold drops, exactly 1 more stall cycle.
- Flush and perf counter:
  - Setup: `flush=1` while a load is in ID; the next instruction uses its `rd`.
  - Required response: no push and no stall.
  - Counter: with `LOAD_USE_PERF_EN`, after 5 stall cycles `stall_count = 5`. After `rst`, `stall_count = 0`.
